// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input vector of a Boolean function in ascending order and captures Y as a truth table.
// Define TT_CHECK_EN to build the golden-table compare that drives mismatch.
module truth_table_sweeper #(
   parameter int N_VARS = 4,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [N_VARS-1:0]     vars,
   input  logic                  y_in,
   output logic                  busy,
   output logic                  done,
   output logic [2**N_VARS-1:0]  truth_table,
   output logic [N_VARS:0]       minterm_count,
   input  logic [2**N_VARS-1:0]  expected,
   output logic                  mismatch
);
   localparam int W = 2**N_VARS;
   localparam logic [1:0] S_IDLE = 2'd0, S_SETTLE = 2'd1, S_SAMPLE = 2'd2, S_DONE = 2'd3;
   localparam logic [2:0] CNT_LD = 3'(SETTLE);
   // With no settle time every vector is sampled in the cycle it is driven.
   localparam logic [1:0] S_VEC = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
   localparam logic [N_VARS-1:0] IDX_LAST = '1;

   logic [1:0]        state_q, state_d;
   logic [N_VARS-1:0] idx_q, idx_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [W-1:0]      table_q, table_d;
   logic [N_VARS:0]   count_q, count_d;
   logic              accept, last;

   assign accept = (state_q == S_IDLE) && start;
   assign last   = (state_q == S_SAMPLE) && (idx_q == IDX_LAST);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      table_d = table_q;
      count_d = count_q;
      case (state_q)
         S_IDLE: if (start) begin
            state_d = S_VEC;
            idx_d   = '0;
            cnt_d   = CNT_LD;
            table_d = '0;
            count_d = '0;
         end
         S_SETTLE: begin
            cnt_d   = cnt_q - 3'd1;
            state_d = (cnt_q <= 3'd1) ? S_SAMPLE : S_SETTLE;
         end
         S_SAMPLE: begin
            table_d[idx_q] = y_in;
            count_d = count_q + {{N_VARS{1'b0}}, y_in};
            state_d = last ? S_DONE : S_VEC;
            idx_d   = last ? idx_q : idx_q + N_VARS'(1);
            cnt_d   = CNT_LD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         table_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         table_q <= table_d;
         count_q <= count_d;
      end
   end

   assign busy          = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
   assign done          = state_q == S_DONE;
   assign vars          = busy ? idx_q : '0;
   assign truth_table   = table_q;
   assign minterm_count = count_q;

`ifdef TT_CHECK_EN
   logic [W-1:0] exp_q, exp_d;
   logic         mis_q, mis_d;

   // Compare against the next-state table so mismatch is valid in the DONE cycle itself.
   always_comb begin
      exp_d = accept ? expected : exp_q;
      mis_d = accept ? 1'b0 : last ? (table_d != exp_q) : mis_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q <= '0;
         mis_q <= 1'b0;
      end else begin
         exp_q <= exp_d;
         mis_q <= mis_d;
      end
   end

   assign mismatch = mis_q;
`else
   logic unused_expected;
   assign unused_expected = ^expected;
   assign mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench for two sweeper instances (N=4/SETTLE=0 and N=3/SETTLE=3).
module tb_truth_table_sweeper;
   localparam int NA = 4, SA = 0, WA = 2**NA;
   localparam int NB = 3, SB = 3, WB = 2**NB;
`ifdef TT_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   typedef struct {
      logic [15:0] tbl;
      int          cnt;
      logic        mis;
      int          k;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0, start_a = 1'b0, start_b = 1'b0;
   logic [WA-1:0] fa = '0, exp_a = '0, tt_a;
   logic [WB-1:0] fb = '0, exp_b = '0, tt_b;
   logic [NA-1:0] vars_a;
   logic [NB-1:0] vars_b;
   logic [NA:0]   mc_a;
   logic [NB:0]   mc_b;
   logic busy_a, done_a, mis_a, busy_b, done_b, mis_b, y_a, y_b;
   int cyc = 0, errors = 0, checks = 0, ia, ib;
   exp_t sb_a[$], sb_b[$];
   exp_t ea, eb;
   logic [15:0] f, e, feq;
   logic [3:0] v;
   bit seen;

   assign y_a = fa[vars_a];
   assign y_b = fb[vars_b];

   truth_table_sweeper #(.N_VARS(NA), .SETTLE(SA)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .vars(vars_a), .y_in(y_a), .busy(busy_a),
      .done(done_a), .truth_table(tt_a), .minterm_count(mc_a), .expected(exp_a), .mismatch(mis_a));

   truth_table_sweeper #(.N_VARS(NB), .SETTLE(SB)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .vars(vars_b), .y_in(y_b), .busy(busy_b),
      .done(done_b), .truth_table(tt_b), .minterm_count(mc_b), .expected(exp_b), .mismatch(mis_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // Expected sweep result straight from the function table: the table is the function itself.
   function automatic exp_t model(input logic [15:0] fn, input logic [15:0] gold, input int w, input int k);
      exp_t r;
      r.tbl = '0;
      r.cnt = 0;
      r.k   = k;
      for (int i = 0; i < w; i++) begin
         r.tbl[i] = fn[i];
         r.cnt += int'(fn[i]);
      end
      r.mis = CHECK && (r.tbl != (gold & 16'((32'd1 << w) - 1)));
      return r;
   endfunction

   always @(negedge clk) if (rst_n) begin
      if (sb_a.size() == 0) begin
         if (busy_a || done_a) chk("a_unrequested_activity", 32'(busy_a | done_a), 0);
      end else begin
         ea = sb_a[0];
         chk("a_active", 32'(busy_a | done_a), 1);
         if (busy_a) begin
            ia = (cyc - ea.k) / (SA + 1);
            chk("a_vars", vars_a, ia);
            chk("a_partial_table", tt_a, ea.tbl & 16'((32'd1 << ia) - 1));
            chk("a_partial_count", mc_a, $countones(ea.tbl & 16'((32'd1 << ia) - 1)));
            chk("a_mismatch_busy", mis_a, 0);
         end
         if (done_a) begin
            void'(sb_a.pop_front());
            chk("a_done_cycle", cyc, ea.k + WA * (SA + 1));
            chk("a_table", tt_a, ea.tbl);
            chk("a_count", mc_a, ea.cnt);
            chk("a_mismatch", mis_a, ea.mis);
            chk("a_vars_done", vars_a, 0);
         end
      end
   end

   always @(negedge clk) if (rst_n) begin
      if (sb_b.size() == 0) begin
         if (busy_b || done_b) chk("b_unrequested_activity", 32'(busy_b | done_b), 0);
      end else begin
         eb = sb_b[0];
         chk("b_active", 32'(busy_b | done_b), 1);
         if (busy_b) begin
            ib = (cyc - eb.k) / (SB + 1);
            chk("b_vars", vars_b, ib);
            chk("b_partial_table", tt_b, eb.tbl & 16'((32'd1 << ib) - 1));
         end
         if (done_b) begin
            void'(sb_b.pop_front());
            chk("b_done_cycle", cyc, eb.k + WB * (SB + 1));
            chk("b_table", tt_b, eb.tbl);
            chk("b_count", mc_b, eb.cnt);
            chk("b_mismatch", mis_b, eb.mis);
         end
      end
   end

   task automatic sweep_a(input logic [15:0] fn, input logic [15:0] gold);
      @(negedge clk);
      fa = fn;
      exp_a = gold;
      start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      sb_a.push_back(model(fn, gold, WA, cyc));
   endtask

   task automatic sweep_b(input logic [15:0] fn, input logic [15:0] gold);
      @(negedge clk);
      fb = fn[WB-1:0];
      exp_b = gold[WB-1:0];
      start_b = 1'b1;
      @(posedge clk);
      #1 start_b = 1'b0;
      sb_b.push_back(model(fn, gold, WB, cyc));
   endtask

   task automatic wait_a();
      for (int i = 0; i < 100 && sb_a.size() > 0; i++) @(posedge clk);
      if (sb_a.size() > 0) begin
         chk("a_timeout", sb_a.size(), 0);
         sb_a.delete();
      end
   endtask

   task automatic wait_b();
      for (int i = 0; i < 100 && sb_b.size() > 0; i++) @(posedge clk);
      if (sb_b.size() > 0) begin
         chk("b_timeout", sb_b.size(), 0);
         sb_b.delete();
      end
   endtask

   task automatic hold_a(input logic [15:0] fn, input logic [15:0] gold);
      exp_t r;
      r = model(fn, gold, WA, 0);
      repeat (3) @(negedge clk);
      chk("a_hold_table", tt_a, r.tbl);
      chk("a_hold_count", mc_a, r.cnt);
      chk("a_hold_mismatch", mis_a, r.mis);
   endtask

   initial begin
      #2;
      chk("rst_vars", vars_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_table", tt_a, 0);
      chk("rst_count", mc_a, 0);
      chk("rst_mismatch", mis_a, 0);
      chk("rst_b_table", tt_b, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         v = 4'(i);
         feq[i] = (v[3] & ~v[0]) | (v[2] & v[0]) | (v[3] & v[1]);
      end
      sweep_a(feq, 16'hFDA0);
      wait_a();
      @(negedge clk);
      chk("eq_table", tt_a, 16'hFDA0);
      chk("eq_count", mc_a, 9);
      chk("eq_mismatch_match", mis_a, 0);
      hold_a(feq, 16'hFDA0);

      sweep_a(feq, 16'hFDA1);
      wait_a();
      hold_a(feq, 16'hFDA1);
      chk("eq_mismatch_differ", mis_a, 32'(CHECK));

      for (int i = 0; i < 16; i++) f[i] = ~i[1];
      sweep_b(f, 16'h0033);
      wait_b();
      @(negedge clk);
      chk("notb_table", tt_b, 8'h33);
      chk("notb_count", mc_b, 4);

      sweep_a(16'hFFFF, 16'hFFFF);
      wait_a();
      hold_a(16'hFFFF, 16'hFFFF);
      chk("ones_count", mc_a, 16);
      sweep_a(16'h0000, 16'h0000);
      wait_a();
      hold_a(16'h0000, 16'h0000);

      f = 16'($urandom);
      sweep_a(f, f);
      repeat (3) @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = done_a;
      end
      chk("repulse_done_seen", 32'(seen), 1);
      start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      @(negedge clk);
      chk("done_start_ignored", busy_a, 0);
      chk("done_start_table_held", tt_a, f);
      sb_a.delete();

      for (int n = 0; n < 6; n++) begin
         f = 16'($urandom);
         e = ($urandom_range(0, 1) == 1) ? f : 16'($urandom);
         fork
            begin sweep_a(f, e); wait_a(); end
            begin sweep_b(~f, ~e); wait_b(); end
         join
      end

      f = 16'($urandom);
      sweep_a(f, f);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = (vars_a == 4'd6);
      end
      chk("reach_vector6", 32'(seen), 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      sb_a.delete();
      #1;
      chk("abort_vars", vars_a, 0);
      chk("abort_busy", busy_a, 0);
      chk("abort_done", done_a, 0);
      chk("abort_table", tt_a, 0);
      chk("abort_count", mc_a, 0);
      chk("abort_mismatch", mis_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      f = 16'($urandom);
      sweep_a(f, f ^ 16'h0100);
      wait_a();
      hold_a(f, f ^ 16'h0100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-capture stage placed directly upstream of the team's combinational logic-function modules (the gate-level and operator-level implementations of 3- and 4-input Boolean equations). On a start request it drives every input combination onto the function's inputs in ascending binary order. After a programmable settle time it samples the function's single output `Y` back into a truth-table register. It reports the captured minterm map and minterm count with a done pulse, so each equation can be exercised and read out as a truth table in hardware.

## Interface
- `N_VARS`, 4 — number of function inputs, legal 2..4; the vector width driven downstream.
- `SETTLE`, 1 — idle cycles between driving a vector and sampling `y_in`, legal 0..7.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — reset is asynchronous and active-low.
- `start`  in  1  — sweep request; accepted only in IDLE.
- `vars`  out  N_VARS  — input vector to the function; MSB = A, then B, C, D; LSB = last variable.
- `y_in`  in  1  — function output `Y` returned from the downstream module.
- `busy`  out  1  — high while a sweep is in progress.
- `done`  out  1  — one-cycle pulse when the sweep completes.
- `table`  out  2**N_VARS  — bit i = sampled `Y` for `vars == i`.
- `minterm_count`  out  N_VARS+1  — number of 1 bits in `table`.
- `expected`  in  2**N_VARS  — golden truth table (see Configuration).
- `mismatch`  out  1  — compare result (see Configuration).

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: `vars`=0, `busy`=0. On `start`=1: index←0, `table`←0, `minterm_count`←0, settle counter←`SETTLE`. Next state is SETTLE, or SAMPLE when `SETTLE`=0.
- SETTLE: `vars`=index. Counter decrements each cycle. Go to SAMPLE on the cycle the counter reaches 1.
- SAMPLE: `table[index]`←`y_in`. `minterm_count` increments when `y_in`=1.
  - If index = 2**N_VARS−1: go to DONE.
  - Otherwise: index+1, reload counter, go to SETTLE (or stay in SAMPLE when `SETTLE`=0).
- DONE: `done`=1 for exactly one cycle, `busy`=0, then IDLE.
- `table` and `minterm_count` hold their final values until the next accepted `start` or reset. During a sweep they show partial progress.
- `start` in SETTLE, SAMPLE or DONE is ignored; no queuing.
- Index never wraps: the sweep ends after the last vector.
- Arithmetic: index is N_VARS bits, settle counter is 3 bits, `minterm_count` is N_VARS+1 bits, so the full-ones count 2**N_VARS is representable.

## Timing
- Reset values: `vars`=0, `busy`=0, `done`=0, `table`=0, `minterm_count`=0, `mismatch`=0, state IDLE.
- Reset asserted mid-sweep aborts immediately. Partial results are discarded and outputs return to the reset values.
- `start` sampled high at edge k: `busy`=1 and `vars`=0 from cycle k+1.
- Each vector is held for `SETTLE`+1 cycles; `y_in` is sampled on the last of them.
- `busy` stays high for 2**N_VARS·(`SETTLE`+1) cycles. `done` pulses in the following cycle, with `table` already final.
- `y_in` is treated as combinational from `vars`. With `SETTLE`=0 the downstream path must settle within one cycle.

## Configuration
- Macro `TT_CHECK_EN`.
- Defined:
  - `expected` is registered on the accepted `start`.
  - In DONE, `mismatch`←(`table` ≠ registered `expected`). It holds until the next accepted `start`, which clears it to 0.
- Undefined:
  - `expected` is ignored.
  - `mismatch` is constant 0.
  - No compare register is built.

## Test plan
- N_VARS=3, SETTLE=1, `y_in`=~B: start → `busy` 16 cycles, `done` at k+17, `table`=8'h33, `minterm_count`=4.
- N_VARS=4, SETTLE=0, `y_in`=(A&~D)|(B&D)|(A&C): `table`=16'hFDA0, `minterm_count`=9, `done` at k+17.
- N_VARS=4, `y_in` tied 1: `table`=16'hFFFF, `minterm_count`=16 (no overflow). Then `y_in` tied 0 with a new start: `table`=0, `minterm_count`=0.
- `start` re-pulsed at cycles k+3 and in the DONE cycle: ignored. Sequence of `vars` is exactly 0..15, each held `SETTLE`+1 cycles.
- `rst_n` low at vector 6: all outputs 0 asynchronously. A new start after release completes a full, correct sweep.
- `TT_CHECK_EN`, `expected`=16'hFDA0 with the matching function: `mismatch`=0. With `expected`=16'hFDA1: `mismatch`=1 from the DONE cycle onward.
